// File: rtl/jpeg_pkg.sv
// Shared constants for the MCU buffer / chroma upsampler.
// Define CHROMA_420_EN for 4:2:0 MCUs (16x16 out); leave it undefined for 4:4:4 (8x8 out).
package jpeg_pkg;

  localparam int BLK_SZ = 64;

`ifdef CHROMA_420_EN
  localparam int MCU_SAMPLES = 6 * BLK_SZ;   // Y0..Y3, Cb, Cr
  localparam int MCU_PIXELS  = 256;
  localparam int MCU_W       = 16;
  localparam int Y_DEPTH     = 4 * BLK_SZ;   // luma samples per bank
`else
  localparam int MCU_SAMPLES = 3 * BLK_SZ;   // Y, Cb, Cr
  localparam int MCU_PIXELS  = 64;
  localparam int MCU_W       = 8;
  localparam int Y_DEPTH     = BLK_SZ;
`endif

  localparam int C_DEPTH = BLK_SZ;           // chroma samples per bank

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mcu_bank_ram.sv
// Simple dual-port RAM: one write port, one registered (1-cycle) read port.
// The top splits the address space into two banks via the address MSB.
module mcu_bank_ram #(
  parameter int DEPTH = 128,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // registered read, only updated when a pixel is issued
  always_ff @(posedge clk)
    if (re) rdata <= mem[raddr];

endmodule

// File: rtl/mcu_upsampler.sv
// Ping-pong MCU buffer + nearest-neighbour chroma upsampler.
// Samples arrive in block order (Y blocks, Cb, Cr); pixels leave in MCU raster
// order with co-sited y/cb/cr. CHROMA_420_EN selects 4:2:0 (else 4:4:4).
module mcu_upsampler
  import jpeg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] sample_i,
  input  logic          sample_vld_i,
  output logic          sample_rdy_o,
  input  logic          pix_hold_i,
  output logic [DW-1:0] y,
  output logic [DW-1:0] cb,
  output logic [DW-1:0] cr,
  output logic          vld_o,
  output logic          mcu_last_o
);

  localparam int WCW = $clog2(MCU_SAMPLES);
  localparam int PCW = $clog2(MCU_PIXELS);
  localparam int YAW = $clog2(Y_DEPTH);
  localparam int CAW = $clog2(C_DEPTH);

  logic [1:0]     full;
  logic           wbank, rbank;
  logic [WCW-1:0] wcnt;
  logic [PCW-1:0] pcnt;
  rd_state_e      state;

  logic           acc, wr_last, issue, rd_last;
  logic           y_we, cb_we, cr_we;
  logic [CAW-1:0] cb_widx, cr_widx;
  logic [YAW-1:0] y_ridx;
  logic [CAW-1:0] c_ridx;
  logic [DW-1:0]  y_rd, cb_rd, cr_rd;

  // ---------------- write side ----------------
  assign sample_rdy_o = !full[wbank];
  assign acc          = sample_vld_i & sample_rdy_o;
  assign wr_last      = (wcnt == WCW'(MCU_SAMPLES - 1));

  // sample counter selects the destination RAM: luma first, then Cb, then Cr
  assign y_we    = acc && (wcnt < WCW'(Y_DEPTH));
  assign cb_we   = acc && (wcnt >= WCW'(Y_DEPTH)) && (wcnt < WCW'(Y_DEPTH + C_DEPTH));
  assign cr_we   = acc && (wcnt >= WCW'(Y_DEPTH + C_DEPTH));
  assign cb_widx = CAW'(wcnt - WCW'(Y_DEPTH));
  assign cr_widx = CAW'(wcnt - WCW'(Y_DEPTH + C_DEPTH));

  // write counter and bank pointer
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (acc) begin
      if (wr_last) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt  <= wcnt + 1'b1;
      end
    end

  // bank full flags; write-complete and read-complete always hit different banks
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      full <= '0;
    end else begin
      if (acc && wr_last)    full[wbank] <= 1'b1;
      if (issue && rd_last)  full[rbank] <= 1'b0;
    end

  // ---------------- read side ----------------
  // Issue straight out of IDLE too, so the first address goes out the cycle
  // full is seen and back-to-back MCUs have no bubble.
  assign issue   = !pix_hold_i && (state == RD_READ || full[rbank]);
  assign rd_last = (pcnt == PCW'(MCU_PIXELS - 1));

`ifdef CHROMA_420_EN
  // pcnt = {py[3:0], px[3:0]}; luma block picked by py[3]/px[3],
  // chroma replicated 2x2 by dropping the LSB of each coordinate
  assign y_ridx = {pcnt[7], pcnt[3], pcnt[6:4], pcnt[2:0]};
  assign c_ridx = {pcnt[7:5], pcnt[3:1]};
`else
  assign y_ridx = pcnt;
  assign c_ridx = pcnt;
`endif

  // read FSM, pixel counter and read bank pointer
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RD_IDLE;
      rbank <= 1'b0;
      pcnt  <= '0;
    end else begin
      if (state == RD_IDLE) begin
        if (full[rbank]) state <= RD_READ;
      end else if (issue && rd_last) begin
        state <= full[~rbank] ? RD_READ : RD_IDLE;
      end
      if (issue) begin
        if (rd_last) begin
          pcnt  <= '0;
          rbank <= ~rbank;
        end else begin
          pcnt  <= pcnt + 1'b1;
        end
      end
    end

  // output valid / last tracks the issue one cycle later, matching RAM latency
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld_o      <= 1'b0;
      mcu_last_o <= 1'b0;
    end else begin
      vld_o      <= issue;
      mcu_last_o <= issue && rd_last;
    end

  // components forced to zero on non-valid cycles
  assign y  = vld_o ? y_rd  : '0;
  assign cb = vld_o ? cb_rd : '0;
  assign cr = vld_o ? cr_rd : '0;

  mcu_bank_ram #(.DEPTH(2 * Y_DEPTH), .DW(DW)) u_y_ram (
    .clk   (clk),
    .we    (y_we),
    .waddr ({wbank, wcnt[YAW-1:0]}),
    .wdata (sample_i),
    .re    (issue),
    .raddr ({rbank, y_ridx}),
    .rdata (y_rd)
  );

  mcu_bank_ram #(.DEPTH(2 * C_DEPTH), .DW(DW)) u_cb_ram (
    .clk   (clk),
    .we    (cb_we),
    .waddr ({wbank, cb_widx}),
    .wdata (sample_i),
    .re    (issue),
    .raddr ({rbank, c_ridx}),
    .rdata (cb_rd)
  );

  mcu_bank_ram #(.DEPTH(2 * C_DEPTH), .DW(DW)) u_cr_ram (
    .clk   (clk),
    .we    (cr_we),
    .waddr ({wbank, cr_widx}),
    .wdata (sample_i),
    .re    (issue),
    .raddr ({rbank, c_ridx}),
    .rdata (cr_rd)
  );

endmodule

// File: tb/tb_mcu_upsampler.sv
// Scoreboard bench for mcu_upsampler (either CHROMA_420_EN build).
`timescale 1ns/1ps
module tb_mcu_upsampler;
  import jpeg_pkg::*;

  localparam int NS = MCU_SAMPLES;
  localparam int NP = MCU_PIXELS;
  localparam int W  = MCU_W;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] sample_i = '0;
  logic       sample_vld_i = 1'b0;
  logic       sample_rdy_o;
  logic       pix_hold_i = 1'b0;
  logic [7:0] y, cb, cr;
  logic       vld_o, mcu_last_o;

  mcu_upsampler #(.DW(8)) dut (
    .clk(clk), .rstn(rstn), .sample_i(sample_i), .sample_vld_i(sample_vld_i),
    .sample_rdy_o(sample_rdy_o), .pix_hold_i(pix_hold_i), .y(y), .cb(cb), .cr(cr),
    .vld_o(vld_o), .mcu_last_o(mcu_last_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] y, cb, cr;
    logic       last;
  } pix_t;

  pix_t       exp_q[$];
  logic [7:0] mcu [NS];
  int n_cmp = 0, n_err = 0;
  int last_acc = 0, not_rdy = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: for every output pixel, look up the samples by coordinates.
  function automatic void push_mcu();
    for (int p = 0; p < NP; p++) begin
      int px, py, yi, ci;
      pix_t e;
      px = p % W;
      py = p / W;
`ifdef CHROMA_420_EN
      yi = ((py / 8) * 2 + (px / 8)) * 64 + (py % 8) * 8 + (px % 8);
      ci = (py / 2) * 8 + (px / 2);
`else
      yi = py * 8 + px;
      ci = yi;
`endif
      e.y    = mcu[yi];
      e.cb   = mcu[Y_DEPTH + ci];
      e.cr   = mcu[Y_DEPTH + C_DEPTH + ci];
      e.last = (p == NP - 1);
      exp_q.push_back(e);
    end
  endfunction

  // ---------------- monitor ----------------
  int   run = 0, max_run = 0, first_vld = -1, cap_n = 0;
  pix_t cap [256];

  always @(negedge clk) begin
    pix_t e;
    if (vld_o) begin
      run++;
      if (run > max_run) max_run = run;
      if (first_vld < 0) first_vld = cyc;
      if (cap_n < 256) begin
        cap[cap_n] = {y, cb, cr, mcu_last_o};
        cap_n++;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pix_y", y, e.y);
        check("pix_cb", cb, e.cb);
        check("pix_cr", cr, e.cr);
        check("pix_last", mcu_last_o, e.last);
      end
    end else begin
      run = 0;
      check("idle_outputs_zero", {y, cb, cr, mcu_last_o}, 0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_one(input logic [7:0] d, input bit gaps);
    bit done = 0;
    int bud = 4000;
    while (!done) begin
      @(negedge clk);
      if (gaps && ($urandom % 2 == 0)) begin
        sample_vld_i = 1'b0;
      end else begin
        sample_vld_i = 1'b1;
        sample_i     = d;
        if (sample_rdy_o) begin
          done     = 1;
          last_acc = cyc;
        end else begin
          not_rdy++;
        end
      end
      bud--;
      if (bud == 0 && !done) begin
        n_cmp++; n_err++;
        $display("FAIL write_timeout: sample never accepted, expected acceptance");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "write timeout");
      end
    end
  endtask

  task automatic send_mcu(input bit gaps);
    for (int i = 0; i < NS; i++) send_one(mcu[i], gaps);
    push_mcu();
  endtask

  task automatic idle_in();
    @(negedge clk);
    sample_vld_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NS; i++) mcu[i] = 8'($urandom);
  endtask

  task automatic wait_drain();
    for (int b = 0; b < 6000 && exp_q.size() > 0; b++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_cb", cb, 0);
    check("rst_cr", cr, 0);
    check("rst_vld", vld_o, 0);
    check("rst_last", mcu_last_o, 0);
    check("rst_rdy", sample_rdy_o, 1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_rdy", sample_rdy_o, 1);

    // partial MCU then reset: nothing may come out
    fill_random();
    for (int i = 0; i < 100; i++) send_one(mcu[i], 0);
    idle_in();
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy", sample_rdy_o, 1);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("partial_discarded_vld", vld_o, 0);

    // directed MCU
`ifdef CHROMA_420_EN
    for (int i = 0; i < 256; i++) mcu[i] = 8'(10 * (i / 64 + 1));
    for (int i = 0; i < 64; i++) begin
      mcu[256 + i] = 8'(i);
      mcu[320 + i] = 8'(255 - i);
    end
`else
    for (int i = 0; i < 192; i++) mcu[i] = 8'(i);
`endif
    cap_n = 0; first_vld = -1; max_run = 0;
    send_mcu(0);
    idle_in();
    wait_drain();
    check("latency_first_vld", first_vld, last_acc + 2);
    check("directed_run_len", max_run, NP);
    check("directed_count", cap_n, NP);
`ifdef CHROMA_420_EN
    check("p00_y", cap[0].y, 10);   check("p00_cb", cap[0].cb, 0);  check("p00_cr", cap[0].cr, 255);
    check("p90_y", cap[9].y, 20);   check("p90_cb", cap[9].cb, 4);  check("p90_cr", cap[9].cr, 251);
    check("pff_y", cap[255].y, 40); check("pff_cb", cap[255].cb, 63); check("pff_cr", cap[255].cr, 192);
    check("pff_last", cap[255].last, 1);
    check("pfe_last", cap[254].last, 0);
`else
    for (int k = 0; k < 64; k++) begin
      check("ramp_y", cap[k].y, k);
      check("ramp_cb", cap[k].cb, 64 + k);
      check("ramp_cr", cap[k].cr, 128 + k);
      check("ramp_last", cap[k].last, (k == 63) ? 1 : 0);
    end
`endif

    // three MCUs streamed continuously
    not_rdy = 0;
    for (int m = 0; m < 3; m++) begin
      fill_random();
      send_mcu(0);
    end
    idle_in();
    wait_drain();
    check("stream_rdy_drops", not_rdy, 0);

    // same data again with 50% valid duty
    send_mcu(1);
    idle_in();
    wait_drain();

    // hold during MCU0 drain while two more MCUs are written
    fill_random();
    send_mcu(0);
    idle_in();
    repeat (8) @(negedge clk);
    pix_hold_i = 1'b1;
    fork
      begin
        repeat (500) @(negedge clk);
        pix_hold_i = 1'b0;
      end
    join_none
    fill_random();
    send_mcu(0);
    idle_in();
    check("hold_rdy_low", sample_rdy_o, 0);
    fill_random();
    send_mcu(0);
    idle_in();
    wait_drain();
    check("hold_rdy_back", sample_rdy_o, 1);

    // two full banks released together drain with no bubble
    pix_hold_i = 1'b1;
    for (int m = 0; m < 2; m++) begin
      fill_random();
      send_mcu(0);
    end
    idle_in();
    check("both_full_rdy", sample_rdy_o, 0);
    check("held_no_vld", vld_o, 0);
    max_run = 0;
    pix_hold_i = 1'b0;
    wait_drain();
    check("b2b_run_len", max_run, 2 * NP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
